// File: rtl/fifo_pkg.sv
// Shared definitions for the destination FIFO: system state encodings, default geometry
// and the decode from system state to FIFO operating mode.
package fifo_pkg;

  localparam logic [3:0] ST_RESET  = 4'b0001;
  localparam logic [3:0] ST_INIT   = 4'b0010;
  localparam logic [3:0] ST_IDLE   = 4'b0100;
  localparam logic [3:0] ST_ACTIVE = 4'b1000;

  localparam int unsigned DATA_WIDTH_DEF = 6;
  localparam int unsigned ADDR_WIDTH_DEF = 2;

  typedef enum logic [1:0] {
    ModeClear,
    ModeInit,
    ModeRun
  } fifo_mode_e;

  // Any code other than INIT/IDLE/ACTIVE, including non-one-hot values, clears like RESET.
  function automatic fifo_mode_e decode_mode(logic [3:0] st);
    if (st == ST_INIT) return ModeInit;
    if (st == ST_IDLE || st == ST_ACTIVE) return ModeRun;
    return ModeClear;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array for the destination FIFO: one write port and one registered read port.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [DATA_WIDTH-1:0] mem_d [Depth];
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  always_comb begin
    mem_d = mem_q;
    if (wr_en_i) mem_d[wr_addr_i] = wr_data_i;
  end

  // Reads the pre-write contents, so a same-slot read and write returns the old word.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en_i) rd_data_d = mem_q[rd_addr_i];
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rd_data_q <= '0;
    else       rd_data_q <= rd_data_d;
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fifo_destino.sv
// Destination-side FIFO with programmable almost_full/almost_empty thresholds latched in INIT.
// Defining FIFO_COUNT_EN adds the fifo_count output (registered occupancy).
module fifo_destino
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned AF_DEFAULT = 3,
  parameter int unsigned AE_DEFAULT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            state,
  input  logic [ADDR_WIDTH:0]   umbral_af,
  input  logic [ADDR_WIDTH:0]   umbral_ae,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  error
`ifdef FIFO_COUNT_EN
  ,
  output logic [ADDR_WIDTH:0]   fifo_count
`endif
);

  localparam int unsigned CntW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] DepthCnt = CntW'(1 << ADDR_WIDTH);

  fifo_mode_e mode;
  logic run, push_ok, pop_ok, overflow, underflow;

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d, af_q, af_d, ae_q, ae_d;
  logic                  valid_q, valid_d, error_q, error_d;

  assign mode = decode_mode(state);

  // A push into a full FIFO is legal only when a pop frees the slot in the same cycle.
  always_comb begin
    run       = (mode == ModeRun);
    pop_ok    = run & pop & ~empty;
    push_ok   = run & push & (~full | pop_ok);
    overflow  = run & push & ~push_ok;
    underflow = run & pop & empty;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    af_d     = af_q;
    ae_d     = ae_q;
    valid_d  = pop_ok;
    error_d  = error_q;
    unique case (mode)
      ModeClear: begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
        error_d  = 1'b0;
      end
      ModeInit: begin
        af_d = umbral_af;
        ae_d = umbral_ae;
      end
      ModeRun: begin
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
        else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
        if (overflow || underflow) error_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      af_q     <= CntW'(AF_DEFAULT);
      ae_q     <= CntW'(AE_DEFAULT);
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
    end
  end

  fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .clk_i    (clk),
    .rst_i    (reset),
    .wr_en_i  (push_ok),
    .wr_addr_i(wr_ptr_q),
    .wr_data_i(data_in),
    .rd_en_i  (pop_ok),
    .rd_addr_i(rd_ptr_q),
    .rd_data_o(data_out)
  );

  assign valid_out    = valid_q;
  assign error        = error_q;
  assign empty        = (count_q == '0);
  assign full         = (count_q == DepthCnt);
  assign almost_full  = (count_q >= af_q);
  assign almost_empty = (count_q <= ae_q);

`ifdef FIFO_COUNT_EN
  assign fifo_count = count_q;
`endif

endmodule

// File: tb/tb_fifo_destino.sv
// Randomised scoreboard bench for fifo_destino: a queue-based reference model predicts
// occupancy, flags and the popped word order; a monitor compares every presented output word.
module tb_fifo_destino;

  localparam int DW = 6;
  localparam int AW = 2;
  localparam int DEPTH = 4;
  localparam logic [3:0] S_RESET  = 4'b0001;
  localparam logic [3:0] S_INIT   = 4'b0010;
  localparam logic [3:0] S_IDLE   = 4'b0100;
  localparam logic [3:0] S_ACTIVE = 4'b1000;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [3:0]    state = S_RESET;
  logic [AW:0]   umbral_af = '0;
  logic [AW:0]   umbral_ae = '0;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          valid_out, empty, full, almost_full, almost_empty, error;
`ifdef FIFO_COUNT_EN
  logic [AW:0]   fifo_count;
`endif

  fifo_destino #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .AF_DEFAULT(3),
    .AE_DEFAULT(1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .state       (state),
    .umbral_af   (umbral_af),
    .umbral_ae   (umbral_ae),
    .push        (push),
    .data_in     (data_in),
    .pop         (pop),
    .data_out    (data_out),
    .valid_out   (valid_out),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .error       (error)
`ifdef FIFO_COUNT_EN
    ,
    .fifo_count  (fifo_count)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: stored words, expected output words, thresholds, sticky error.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] exp_q[$];
  int m_af = 3;
  int m_ae = 1;
  bit m_err = 1'b0;
  bit m_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, required %0h", name, $time, act, exp);
    end
  endtask

  // Applies the rules for one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit do_pop, do_push;
    if (state == S_INIT) begin
      m_af = int'(umbral_af);
      m_ae = int'(umbral_ae);
      m_valid = 1'b0;
    end else if (state == S_IDLE || state == S_ACTIVE) begin
      do_pop  = pop && (mq.size() > 0);
      do_push = push && ((mq.size() < DEPTH) || do_pop);
      if ((pop && !do_pop) || (push && !do_push)) m_err = 1'b1;
      if (do_pop) exp_q.push_back(mq.pop_front());
      if (do_push) mq.push_back(data_in);
      m_valid = do_pop;
    end else begin
      mq.delete();
      m_err = 1'b0;
      m_valid = 1'b0;
    end
  endtask

  task automatic check_flags();
    check("empty", 32'(empty), 32'(mq.size() == 0));
    check("full", 32'(full), 32'(mq.size() == DEPTH));
    check("almost_full", 32'(almost_full), 32'(mq.size() >= m_af));
    check("almost_empty", 32'(almost_empty), 32'(mq.size() <= m_ae));
    check("error", 32'(error), 32'(m_err));
    check("valid_out", 32'(valid_out), 32'(m_valid));
`ifdef FIFO_COUNT_EN
    check("fifo_count", 32'(fifo_count), 32'(mq.size()));
`endif
  endtask

  task automatic cyc(input logic [3:0] st, input bit ps, input logic [DW-1:0] d, input bit pp);
    state = st;
    push = ps;
    data_in = d;
    pop = pp;
    @(posedge clk);
    model_edge();
    #1;
    check_flags();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_empty"}, 32'(empty), 32'd1);
    check({tag, "_full"}, 32'(full), 32'd0);
    check({tag, "_almost_full"}, 32'(almost_full), 32'd0);
    check({tag, "_almost_empty"}, 32'(almost_empty), 32'd1);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_valid_out"}, 32'(valid_out), 32'd0);
    check({tag, "_data_out"}, 32'(data_out), 32'd0);
  endtask

  // Monitor: every word the DUT presents must be the next one the model popped.
  always @(negedge clk) begin
    if (!reset && valid_out) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL spurious_output at %0t: got data_out=%0h, required no output",
                 $time, data_out);
      end else begin
        check("data_out", 32'(data_out), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    #2 reset = 1'b1;
    #1 check_reset_outputs("por");
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b0;

    // Thresholds af=2, ae=0, then two pushes reach almost_full.
    umbral_af = 3'd2;
    umbral_ae = 3'd0;
    cyc(S_INIT, 0, '0, 0);
    cyc(S_ACTIVE, 1, 6'h11, 0);
    cyc(S_ACTIVE, 1, 6'h22, 0);
    cyc(S_ACTIVE, 0, '0, 1);
    cyc(S_ACTIVE, 0, '0, 1);

    // Fill, overflow with 0x05, drain four words.
    for (int i = 1; i <= 5; i++) cyc(S_ACTIVE, 1, 6'(i), 0);
    for (int i = 0; i < 4; i++) cyc(S_ACTIVE, 0, '0, 1);
    cyc(S_RESET, 0, '0, 0);

    // Simultaneous push and pop while full.
    for (int i = 0; i < 4; i++) cyc(S_ACTIVE, 1, 6'(8'h11 + i), 0);
    cyc(S_ACTIVE, 1, 6'h3F, 1);
    for (int i = 0; i < 4; i++) cyc(S_ACTIVE, 0, '0, 1);
    cyc(S_RESET, 0, '0, 0);

    // Simultaneous push and pop while empty: underflow, no bypass.
    cyc(S_ACTIVE, 1, 6'h2A, 1);
    cyc(S_ACTIVE, 0, '0, 1);
    cyc(S_IDLE, 0, '0, 0);

    // Soft clear keeps the INIT thresholds.
    cyc(S_ACTIVE, 1, 6'h05, 0);
    cyc(S_ACTIVE, 1, 6'h06, 0);
    cyc(S_RESET, 0, '0, 0);
    cyc(S_IDLE, 1, 6'h07, 0);
    cyc(S_IDLE, 1, 6'h08, 0);
    cyc(S_IDLE, 0, '0, 1);
    cyc(S_IDLE, 1, 6'h09, 0);
    cyc(S_IDLE, 1, 6'h0A, 0);

    // Asynchronous reset mid-burst, between clock edges.
    #2 reset = 1'b1;
    #1 check_reset_outputs("async");
    mq.delete();
    exp_q.delete();
    m_err = 1'b0;
    m_valid = 1'b0;
    m_af = 3;
    m_ae = 1;
    @(posedge clk);
    #2 reset = 1'b0;
    cyc(S_IDLE, 0, '0, 0);

    // Pointer wrap with interleaved push/pop pairs.
    for (int i = 0; i < 10; i++) begin
      cyc(S_ACTIVE, 1, 6'(i), 0);
      cyc(S_ACTIVE, 0, '0, 1);
    end

    // Random traffic with occasional INIT, RESET and illegal state codes.
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 19);
      if (r == 1) begin
        umbral_af = 3'($urandom_range(0, 7));
        umbral_ae = 3'($urandom_range(0, 7));
      end
      cyc((r == 0) ? S_RESET : (r == 1) ? S_INIT : (r == 2) ? 4'b0110 :
          (r < 10) ? S_IDLE : S_ACTIVE,
          1'($urandom_range(0, 1)), 6'($urandom), 1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 6; i++) cyc(S_ACTIVE, 0, '0, 1);
    cyc(S_IDLE, 0, '0, 0);
    cyc(S_IDLE, 0, '0, 0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
